// File: rtl/dotp_accelerator_if.sv
`default_nettype none
// ============================================================================
// Module      : dotp_accelerator_if
// Description : CPU native memory bus bundle (valid/ready/addr/wdata/wstrb/
//               rdata) used between a bus master and the dot-product engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface dotp_accelerator_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dotp_accelerator.sv
`default_nettype none
// ============================================================================
// Module      : dotp_accelerator
// Description : Memory-mapped dot-product engine. Two N-element W-bit operand
//               vectors are multiplied and accumulated one element per cycle
//               into a 64-bit accumulator. Command/status register, per-byte
//               write strobes and operand readback.
//               Optional build macro DOTP_SIGNED_EN selects two's complement
//               operands, signed accumulation and sign-extended readback.
// Revision    : 1.0 - initial release
// ============================================================================
module dotp_accelerator #(
    parameter logic [31:0] ADDR_BASE = 32'h0110_0000,
    parameter int          N         = 3,
    parameter int          W         = 32
) (
    input  logic              clk,
    input  logic              resetn,
    dotp_accelerator_if.slave mem
);

    localparam int              IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [6:0]      N_L      = 7'(N);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [W-1:0]     a_mem [N];
    logic [W-1:0]     b_mem [N];
    logic [63:0]      acc;
    logic [IDX_W-1:0] idx;
    logic             done_q;
    logic             err_q;
    logic             ready_q;
    logic [31:0]      rdata_q;

    logic [31:0]      off;
    logic             in_win;
    logic             is_write;
    logic             sel_ctrl;
    logic             sel_lo;
    logic             sel_hi;
    logic             sel_a;
    logic             sel_b;
    logic             decoded;
    logic             fire;
    logic [IDX_W-1:0] ab_idx;
    logic             busy;
    logic             cmd_start;
    logic             cmd_clear;
    logic             ab_write;
    logic [31:0]      rd_next;
    logic [63:0]      prod;

    // Operand value as seen on the bus (sign- or zero-extended to 32 bits).
    function automatic logic [31:0] ext32(input logic [W-1:0] v);
`ifdef DOTP_SIGNED_EN
        return 32'($signed(v));
`else
        return 32'(v);
`endif
    endfunction

    // Byte-strobed merge of new write data over the current operand value.
    function automatic logic [W-1:0] merge(input logic [31:0] old_v,
                                           input logic [31:0] wd,
                                           input logic [3:0]  st);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = st[k] ? wd[8*k +: 8] : old_v[8*k +: 8];
        end
        return r[W-1:0];
    endfunction

    assign busy          = (state == S_RUN);
    assign mem.mem_ready = ready_q;
    assign mem.mem_rdata = rdata_q;

    // Address decode; only mapped registers (and in-range operand slots) answer.
    always_comb begin
        off       = mem.mem_addr - ADDR_BASE;
        in_win    = (off < 32'h400);
        is_write  = |mem.mem_wstrb;
        sel_ctrl  = in_win && (off[9:2] == 8'h00);
        sel_lo    = in_win && (off[9:2] == 8'h01);
        sel_hi    = in_win && (off[9:2] == 8'h02);
        sel_a     = in_win && (off[9:8] == 2'b01) && ({1'b0, off[7:2]} < N_L);
        sel_b     = in_win && (off[9:8] == 2'b10) && ({1'b0, off[7:2]} < N_L);
        ab_idx    = off[IDX_W+1:2];
        decoded   = sel_ctrl || ((sel_lo || sel_hi) && !is_write) || sel_a || sel_b;
        fire      = mem.mem_valid && !ready_q && decoded;
        cmd_start = fire && is_write && sel_ctrl && mem.mem_wstrb[0] && mem.mem_wdata[0];
        cmd_clear = fire && is_write && sel_ctrl && mem.mem_wstrb[0] && mem.mem_wdata[1];
        ab_write  = fire && is_write && (sel_a || sel_b);
    end

    // Read data selection for the currently addressed register.
    always_comb begin
        rd_next = '0;
        if (sel_ctrl) begin
            rd_next = {29'd0, err_q, done_q, busy};
        end else if (sel_lo) begin
            rd_next = acc[31:0];
        end else if (sel_hi) begin
            rd_next = acc[63:32];
        end else if (sel_a) begin
            rd_next = ext32(a_mem[ab_idx]);
        end else if (sel_b) begin
            rd_next = ext32(b_mem[ab_idx]);
        end
    end

    // Product of the current element pair, extended to the accumulator width.
    always_comb begin
`ifdef DOTP_SIGNED_EN
        prod = 64'($signed(a_mem[idx])) * 64'($signed(b_mem[idx]));
`else
        prod = 64'(a_mem[idx]) * 64'(b_mem[idx]);
`endif
    end

    // Bus acknowledge: single-cycle pulse, read data captured on read accesses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= fire;
            if (fire && !is_write) begin
                rdata_q <= rd_next;
            end
        end
    end

    // Operand storage; writes while a run is in progress are dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (ab_write && !busy) begin
            if (sel_a) begin
                a_mem[ab_idx] <= merge(ext32(a_mem[ab_idx]), mem.mem_wdata, mem.mem_wstrb);
            end
            if (sel_b) begin
                b_mem[ab_idx] <= merge(ext32(b_mem[ab_idx]), mem.mem_wdata, mem.mem_wstrb);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: START launches a run, the last element ends it.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (cmd_start) state_next = S_RUN;
            S_RUN:   if (idx == LAST_IDX) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Multiply-accumulate datapath and element index.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
            idx <= '0;
        end else if (state == S_IDLE) begin
            if (cmd_start) begin
                acc <= '0;
                idx <= '0;
            end
        end else begin
            acc <= acc + prod;
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // Status flags: CLEAR is applied first so a same-write START or a busy-time
    // violation in the same cycle still leaves its mark.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (cmd_clear) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (busy) begin
                if (ab_write || cmd_start) begin
                    err_q <= 1'b1;
                end
                if (idx == LAST_IDX) begin
                    done_q <= 1'b1;
                end
            end else if (cmd_start) begin
                done_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dotp_accelerator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dotp_accelerator
// Description : Self-checking bench for dotp_accelerator (N=3, W=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dotp_accelerator;

    localparam logic [31:0] BASE   = 32'h0110_0000;
    localparam int          N      = 3;
    localparam logic [31:0] CTRL   = BASE;
    localparam logic [31:0] RES_LO = BASE + 32'h4;
    localparam logic [31:0] RES_HI = BASE + 32'h8;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          exp_ack;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    logic [31:0] ma [N];
    logic [31:0] mb [N];
    vec_t        tbl [$];

    dotp_accelerator_if bus();

    dotp_accelerator #(.ADDR_BASE(BASE), .N(N), .W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .mem    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] a_addr(input int i);
        return BASE + 32'h100 + 32'(i) * 4;
    endfunction

    function automatic logic [31:0] b_addr(input int i);
        return BASE + 32'h200 + 32'(i) * 4;
    endfunction

    // Reference: dot product computed directly from the operand arrays.
    function automatic logic [63:0] model_dot();
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < N; i++) begin
`ifdef DOTP_SIGNED_EN
            s = s + 64'(longint'($signed(ma[i])) * longint'($signed(mb[i])));
`else
            s = s + 64'(ma[i]) * 64'(mb[i]);
`endif
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus access, starting and ending on a falling edge.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int budget,
                          output bit acked, output logic [31:0] d);
        acked = 1'b0;
        d     = '0;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = strb;
        bus.mem_valid = 1'b1;
        for (int c = 0; c < budget && !acked; c++) begin
            @(negedge clk);
            if (bus.mem_ready) begin
                acked = 1'b1;
                d     = bus.mem_rdata;
            end
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'd0;
    endtask

    task automatic wr(input string name, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
        bit          ack;
        logic [31:0] d;
        access(addr, data, strb, 4, ack, d);
        chk({name, " ack"}, 64'(ack), 64'd1);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, output logic [31:0] d);
        bit ack;
        access(addr, 32'd0, 4'd0, 4, ack, d);
        chk({name, " ack"}, 64'(ack), 64'd1);
    endtask

    task automatic start_run();
        wr("start", CTRL, 32'h1, 4'b0001);
        start_cyc = cyc;
    endtask

    task automatic poll_done(output int unsigned lat);
        logic [31:0] d;
        d = '0;
        for (int p = 0; p < 20 && !d[1]; p++) begin
            rd("poll", CTRL, d);
        end
        lat = cyc - start_cyc;
        chk("done reached", 64'(d[1]), 64'd1);
    endtask

    task automatic check_result(input string name, input logic [63:0] exp);
        logic [31:0] lo;
        logic [31:0] hi;
        rd({name, " lo"}, RES_LO, lo);
        rd({name, " hi"}, RES_HI, hi);
        chk({name, " res"}, {hi, lo}, exp);
    endtask

    task automatic add(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit exp_ack, input bit chk_rd,
                       input logic [31:0] exp_rd);
        vec_t v;
        v.name = name; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.exp_ack = exp_ack; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] v;
        logic [3:0]  s;
        bit          ack;
        int unsigned lat;
        int          k;

        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;

        // ---- vector table: reset state, strobe gating, operands, decode holes
        add("rst ctrl",      CTRL,          32'h0,        4'h0, 1, 1, 32'h0);
        add("rst res_lo",    RES_LO,        32'h0,        4'h0, 1, 1, 32'h0);
        add("rst res_hi",    RES_HI,        32'h0,        4'h0, 1, 1, 32'h0);
        add("rst a0",        a_addr(0),     32'h0,        4'h0, 1, 1, 32'h0);
        add("rst b2",        b_addr(2),     32'h0,        4'h0, 1, 1, 32'h0);
        add("ctrl nostrb",   CTRL,          32'hFFFF_FF03, 4'b1110, 1, 0, 32'h0);
        add("ctrl idle",     CTRL,          32'h0,        4'h0, 1, 1, 32'h0);
        add("wr a0",         a_addr(0),     32'd1,        4'hF, 1, 0, 32'h0);
        add("wr a1",         a_addr(1),     32'd2,        4'hF, 1, 0, 32'h0);
        add("wr a2",         a_addr(2),     32'd3,        4'hF, 1, 0, 32'h0);
        add("wr b0",         b_addr(0),     32'd4,        4'hF, 1, 0, 32'h0);
        add("wr b1",         b_addr(1),     32'd5,        4'hF, 1, 0, 32'h0);
        add("wr b2",         b_addr(2),     32'd6,        4'hF, 1, 0, 32'h0);
        add("rb a1",         a_addr(1),     32'h0,        4'h0, 1, 1, 32'd2);
        add("rb b2",         b_addr(2),     32'h0,        4'h0, 1, 1, 32'd6);
        add("hole a3",       BASE + 32'h10C, 32'h0,       4'h0, 0, 0, 32'h0);
        add("hole b3",       BASE + 32'h20C, 32'h0,       4'h0, 0, 0, 32'h0);
        add("hole win end",  BASE + 32'h400, 32'h0,       4'h0, 0, 0, 32'h0);
        add("hole below",    BASE - 32'h4,   32'h0,       4'h0, 0, 0, 32'h0);
        add("hole res wr",   RES_LO,        32'h1234,     4'hF, 0, 0, 32'h0);
        add("hole gap",      BASE + 32'h0C, 32'h0,        4'h0, 0, 0, 32'h0);

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        foreach (tbl[t]) begin
            access(tbl[t].addr, tbl[t].wdata, tbl[t].strb, tbl[t].exp_ack ? 4 : 8, ack, d);
            chk({tbl[t].name, " ack"}, 64'(ack), 64'(tbl[t].exp_ack));
            if (tbl[t].chk_rd) chk({tbl[t].name, " data"}, 64'(d), 64'(tbl[t].exp_rd));
        end
        ma = '{32'd1, 32'd2, 32'd3};
        mb = '{32'd4, 32'd5, 32'd6};

        // ---- basic run: busy on immediate poll, done within N+1 cycles
        start_run();
        rd("busy poll", CTRL, d);
        chk("busy poll", 64'(d[2:0]), 64'h1);
        poll_done(lat);
        chk("done latency ok", 64'(lat <= 4), 64'd1);
        rd("ctrl after run", CTRL, d);
        chk("ctrl after run", 64'(d[2:0]), 64'h2);
        check_result("1..3x4..6", 64'd32);

        // ---- all-ones operands: 64-bit wrap (or -1*-1 when signed)
        for (int i = 0; i < N; i++) begin
            wr("ones a", a_addr(i), 32'hFFFF_FFFF, 4'hF);
            wr("ones b", b_addr(i), 32'hFFFF_FFFF, 4'hF);
            ma[i] = 32'hFFFF_FFFF;
            mb[i] = 32'hFFFF_FFFF;
        end
        start_run();
        poll_done(lat);
`ifdef DOTP_SIGNED_EN
        check_result("all ones", 64'h0000_0000_0000_0003);
`else
        check_result("all ones", 64'hFFFF_FFFA_0000_0003);
`endif

        // ---- byte strobes, one ready pulse per access
        wr("strb full", a_addr(0), 32'h1122_3344, 4'hF);
        @(negedge clk);
        chk("pulse full", 64'(bus.mem_ready), 64'd0);
        wr("strb byte1", a_addr(0), 32'h0000_AA00, 4'b0010);
        @(negedge clk);
        chk("pulse byte1", 64'(bus.mem_ready), 64'd0);
        rd("strb rb", a_addr(0), d);
        @(negedge clk);
        chk("pulse rd", 64'(bus.mem_ready), 64'd0);
        chk("strb rb", 64'(d), 64'h1122_AA44);

        // ---- operand write during RUN is dropped and flags ERR
        for (int i = 0; i < N; i++) begin
            wr("set a", a_addr(i), 32'(i + 1), 4'hF);
            wr("set b", b_addr(i), 32'(i + 4), 4'hF);
            ma[i] = 32'(i + 1);
            mb[i] = 32'(i + 4);
        end
        wr("clear", CTRL, 32'h2, 4'b0001);
        start_run();
        wr("b1 in run", b_addr(1), 32'd7, 4'hF);
        poll_done(lat);
        check_result("b wr in run", model_dot());
        rd("ctrl err", CTRL, d);
        chk("ctrl err", 64'(d[2:0]), 64'h6);
        rd("b1 kept", b_addr(1), d);
        chk("b1 kept", 64'(d), 64'd5);
        wr("clear2", CTRL, 32'h2, 4'b0001);
        rd("ctrl cleared", CTRL, d);
        chk("ctrl cleared", 64'(d[2:0]), 64'h0);

        // ---- START during RUN is ignored and flags ERR
        start_run();
        wr("start in run", CTRL, 32'h1, 4'b0001);
        poll_done(lat);
        check_result("start in run", model_dot());
        rd("ctrl err2", CTRL, d);
        chk("ctrl err2", 64'(d[2:0]), 64'h6);
        wr("clear3", CTRL, 32'h3, 4'b0001);
        poll_done(lat);
        rd("clear+start", CTRL, d);
        chk("clear+start", 64'(d[2:0]), 64'h2);

        // ---- reset pulse in the middle of a run
        start_run();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < N; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        rd("ctrl after rst", CTRL, d);
        chk("ctrl after rst", 64'(d), 64'h0);
        check_result("res after rst", 64'd0);
        rd("a0 after rst", a_addr(0), d);
        chk("a0 after rst", 64'(d), 64'h0);
        start_run();
        poll_done(lat);
        check_result("run after rst", 64'd0);

        // ---- randomized operands against the reference model
        for (int it = 0; it < 25; it++) begin
            wr("rnd clear", CTRL, 32'h2, 4'b0001);
            for (int i = 0; i < N; i++) begin
                v = $urandom;
                wr("rnd a", a_addr(i), v, 4'hF);
                ma[i] = v;
                v = $urandom;
                wr("rnd b", b_addr(i), v, 4'hF);
                mb[i] = v;
            end
            k = $urandom_range(0, N - 1);
            s = 4'($urandom_range(1, 15));
            v = $urandom;
            wr("rnd part", b_addr(k), v, s);
            for (int bb = 0; bb < 4; bb++) begin
                if (s[bb]) mb[k][8*bb +: 8] = v[8*bb +: 8];
            end
            rd("rnd rb", b_addr(k), d);
            chk("rnd rb", 64'(d), 64'(mb[k]));
            start_run();
            poll_done(lat);
            check_result("rnd", model_dot());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
